// File: rtl/sound_note_sequencer_if.sv
// Bus between the CPU-side note queue controls / tone generator side and the note sequencer.
interface sound_note_sequencer_if;
    logic [25:0] note_max_count;
    logic [15:0] note_duration_ms;
    logic        note_push;
    logic        stop;
    logic [25:0] max_count;
    logic        latch_max_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_dropped;
    logic        playing;
    logic        note_done;

    modport master (
        output note_max_count, note_duration_ms, note_push, stop,
        input  max_count, latch_max_count, fifo_full, fifo_empty, push_dropped, playing, note_done
    );

    modport slave (
        input  note_max_count, note_duration_ms, note_push, stop,
        output max_count, latch_max_count, fifo_full, fifo_empty, push_dropped, playing, note_done
    );
endinterface

// File: rtl/sound_note_sequencer.sv
// Plays queued {max_count, duration_ms} notes back-to-back into the buzzer tone generator,
// latching silence when the queue drains or on stop.
module sound_note_sequencer #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_async,
    sound_note_sequencer_if.slave bus
);
    localparam int T  = CLK_HZ / 1000;
    localparam int PW = (T > 1) ? $clog2(T) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(T - 1);

    typedef struct packed {
        logic [25:0] max_count;
        logic [15:0] duration_ms;
    } note_t;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, SILENCE} state_t;

    state_t        state_q, state_d;
    note_t         mem [FIFO_DEPTH];
    note_t         head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          full_q, empty_q;
    logic [15:0]   ms_cnt;
    logic [PW-1:0] presc;
    logic [25:0]   max_count_q;
    logic          latch_q, dropped_q;
    logic          pop, push_ok, note_last;

    assign head      = mem[rd_ptr];
    assign note_last = (state_q == PLAY) && (ms_cnt == 16'd1) && (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
                LOAD: state_d = PLAY;
                PLAY: if (note_last) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = SILENCE;
                    end
                end
                SILENCE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A full queue still accepts a push when the head is leaving in the same cycle.
    assign push_ok = bus.note_push && !bus.stop && (!full_q || pop);

    always_comb begin
        count_d = count;
        if (bus.stop)             count_d = '0;
        else if (push_ok && !pop) count_d = count + CW'(1);
        else if (!push_ok && pop) count_d = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{max_count: bus.note_max_count, duration_ms: bus.note_duration_ms};
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count   <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
            if (bus.stop) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Counters are armed on the pop edge so LOAD is already cycle 0 of the note.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            max_count_q <= '0;
            latch_q     <= 1'b0;
            dropped_q   <= 1'b0;
            ms_cnt      <= '0;
            presc       <= '0;
        end else begin
            latch_q   <= 1'b0;
            dropped_q <= bus.note_push && !push_ok;
            if (bus.stop) begin
                max_count_q <= '0;
                latch_q     <= 1'b1;
                ms_cnt      <= '0;
                presc       <= '0;
            end else if (pop) begin
                max_count_q <= head.max_count;
                latch_q     <= 1'b1;
                ms_cnt      <= (head.duration_ms == 16'd0) ? 16'd1 : head.duration_ms;
                presc       <= '0;
            end else if (note_last) begin
                max_count_q <= '0;
                latch_q     <= 1'b1;
            end else if (state_q == LOAD || state_q == PLAY) begin
                if (presc == PRESC_MAX) begin
                    presc  <= '0;
                    ms_cnt <= ms_cnt - 16'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign bus.max_count       = max_count_q;
    assign bus.latch_max_count = latch_q;
    assign bus.fifo_full       = full_q;
    assign bus.fifo_empty      = empty_q;
    assign bus.push_dropped    = dropped_q;
    assign bus.playing         = (state_q == LOAD) || (state_q == PLAY);
    assign bus.note_done       = note_last && !bus.stop;
endmodule

// File: tb/tb_sound_note_sequencer.sv
// Directed bench for sound_note_sequencer at CLK_HZ=10000 (10 cycles/ms), FIFO_DEPTH=4.
module tb_sound_note_sequencer;
    logic clk;
    logic rst_async;
    int   n_chk;
    int   n_err;

    int          lat_t [8];
    logic [25:0] lat_v [8];
    int          n_lat, n_done, first_done;

    sound_note_sequencer_if bus ();

    sound_note_sequencer #(.CLK_HZ(10000), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [25:0] mc, input logic [15:0] dur);
        bus.note_max_count   = mc;
        bus.note_duration_ms = dur;
        bus.note_push        = 1'b1;
        tick();
        bus.note_push        = 1'b0;
    endtask

    // Index k is the k-th cycle after the call point.
    task automatic watch(input int n);
        n_lat      = 0;
        n_done     = 0;
        first_done = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.latch_max_count) begin
                if (n_lat < 8) begin
                    lat_t[n_lat] = k;
                    lat_v[n_lat] = bus.max_count;
                end
                n_lat++;
            end
            if (bus.note_done) begin
                if (first_done < 0) first_done = k;
                n_done++;
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_max_count"}, bus.max_count, 0);
        chk({tag, "_latch"},     bus.latch_max_count, 0);
        chk({tag, "_full"},      bus.fifo_full, 0);
        chk({tag, "_empty"},     bus.fifo_empty, 1);
        chk({tag, "_dropped"},   bus.push_dropped, 0);
        chk({tag, "_playing"},   bus.playing, 0);
        chk({tag, "_done"},      bus.note_done, 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        bus.note_max_count   = '0;
        bus.note_duration_ms = '0;
        bus.note_push        = 1'b0;
        bus.stop             = 1'b0;
        rst_async            = 1'b1;
        #1;
        chk_idle_outputs("rst");
        tick(); tick();
        rst_async = 1'b0;
        tick();

        // single note 3 ms
        push(26'd1000, 16'd3);
        watch(45);
        chk("t2_nlat",   n_lat, 2);
        chk("t2_lat0_t", lat_t[0], 1);
        chk("t2_lat0_v", lat_v[0], 1000);
        chk("t2_done_t", first_done, 30);
        chk("t2_lat1_t", lat_t[1], 31);
        chk("t2_lat1_v", lat_v[1], 0);
        chk("t2_playing_end", bus.playing, 0);

        // three back-to-back including a rest
        bus.note_max_count = 26'd100; bus.note_duration_ms = 16'd1; bus.note_push = 1'b1;
        tick();
        bus.note_max_count = 26'd0;   bus.note_duration_ms = 16'd2;
        tick();
        chk("t3_first_latch", bus.latch_max_count, 1);
        chk("t3_first_val",   bus.max_count, 100);
        chk("t3_playing",     bus.playing, 1);
        bus.note_max_count = 26'd300; bus.note_duration_ms = 16'd1;
        tick();
        bus.note_push = 1'b0;
        watch(45);
        chk("t3_nlat",   n_lat, 3);
        chk("t3_lat1_t", lat_t[0], 9);
        chk("t3_lat1_v", lat_v[0], 0);
        chk("t3_lat2_t", lat_t[1], 29);
        chk("t3_lat2_v", lat_v[1], 300);
        chk("t3_lat3_t", lat_t[2], 39);
        chk("t3_lat3_v", lat_v[2], 0);
        chk("t3_ndone",  n_done, 3);

        // zero duration acts as 1 ms
        push(26'd500, 16'd0);
        watch(20);
        chk("t6_nlat",   n_lat, 2);
        chk("t6_lat0_v", lat_v[0], 500);
        chk("t6_gap",    lat_t[1] - lat_t[0], 10);
        chk("t6_lat1_v", lat_v[1], 0);

        // fill, overflow, push on the pop boundary while full
        push(26'd11, 16'd5);
        push(26'd12, 16'd1);
        push(26'd13, 16'd1);
        push(26'd14, 16'd1);
        push(26'd15, 16'd1);
        chk("t4_full",       bus.fifo_full, 1);
        chk("t4_no_drop",    bus.push_dropped, 0);
        push(26'd99, 16'd1);
        chk("t4_dropped",    bus.push_dropped, 1);
        chk("t4_still_full", bus.fifo_full, 1);
        begin
            int w;
            w = 0;
            while (!bus.note_done && w < 100) begin
                tick();
                w++;
            end
            chk("t4_done_seen", bus.note_done, 1);
        end
        push(26'd77, 16'd1);
        chk("t4_bnd_no_drop", bus.push_dropped, 0);
        chk("t4_bnd_full",    bus.fifo_full, 1);
        chk("t4_bnd_latch",   bus.latch_max_count, 1);
        chk("t4_bnd_val",     bus.max_count, 12);
        watch(60);
        chk("t4_nlat",   n_lat, 5);
        chk("t4_v0",     lat_v[0], 13);
        chk("t4_v1",     lat_v[1], 14);
        chk("t4_v2",     lat_v[2], 15);
        chk("t4_v3",     lat_v[3], 77);
        chk("t4_v4",     lat_v[4], 0);
        chk("t4_t4",     lat_t[4], 50);

        // stop mid-play with three queued, coincident push dropped
        push(26'd21, 16'd5);
        push(26'd22, 16'd5);
        push(26'd23, 16'd5);
        push(26'd24, 16'd5);
        tick(); tick(); tick(); tick(); tick();
        chk("t5_pre_playing", bus.playing, 1);
        bus.stop = 1'b1;
        bus.note_max_count = 26'd55; bus.note_duration_ms = 16'd1; bus.note_push = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.note_push = 1'b0;
        chk("t5_empty",   bus.fifo_empty, 1);
        chk("t5_full",    bus.fifo_full, 0);
        chk("t5_latch",   bus.latch_max_count, 1);
        chk("t5_val",     bus.max_count, 0);
        chk("t5_playing", bus.playing, 0);
        chk("t5_done",    bus.note_done, 0);
        chk("t5_dropped", bus.push_dropped, 1);
        watch(80);
        chk("t5_nlat",  n_lat, 0);
        chk("t5_ndone", n_done, 0);

        // stop while idle still pulses the latch
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("idle_stop_latch", bus.latch_max_count, 1);
        chk("idle_stop_val",   bus.max_count, 0);

        // async reset in the middle of a note
        push(26'd1000, 16'd3);
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("t1_pre_playing", bus.playing, 1);
        rst_async = 1'b1;
        #1;
        chk_idle_outputs("t1");
        tick(); tick();
        rst_async = 1'b0;
        watch(50);
        chk("t1_nlat", n_lat, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
